// File: rtl/bldc_commutator.sv
// bldc_commutator: six-step BLDC commutation from filtered hall sensors with dead time, brake, fault latch and speed measurement
// Ports: clk/reset (async, active high); hall, fault_n raw async inputs; pwm_in gated onto the active high side;
// dir/enable/brake/deadtime select the target pattern; gate_h/gate_l drive the gate driver;
// comm_state, hall_error, fault_latched, step_count, step_period report status.
module bldc_commutator #(
  parameter int DT_W     = 12,
  parameter int FILT_LEN = 16,
  parameter int STEP_W   = 32,
  parameter int PERIOD_W = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2:0]               hall,
  input  logic                     pwm_in,
  input  logic                     dir,
  input  logic                     enable,
  input  logic                     brake,
  input  logic                     fault_n,
  input  logic [DT_W-1:0]          deadtime,
  output logic [2:0]               gate_h,
  output logic [2:0]               gate_l,
  output logic [2:0]               comm_state,
  output logic                     hall_error,
  output logic                     fault_latched,
  output logic signed [STEP_W-1:0] step_count,
  output logic [PERIOD_W-1:0]      step_period
);
  typedef enum logic [1:0] {IDLE, DEADTIME, DRIVE, FAULT} state_t;
  localparam logic [7:0] FL = 8'(FILT_LEN);
  localparam logic [PERIOD_W-1:0] PER_MAX = '1;
  logic [2:0] hall_s1_q, hall_s2_q, hall_last_q, hall_filt_q, hall_filt_d;
  logic fault_s1_q, fault_s2_q;
  logic [7:0] filt_cnt_q, filt_cnt_d;
  logic [2:0] comm_state_q, comm_state_d;
  logic hall_error_q, hall_error_d;
  logic signed [STEP_W-1:0] step_count_q, step_count_d;
  logic [PERIOD_W-1:0] per_cnt_q, per_cnt_d, step_period_q, step_period_d;
  logic [5:0] tgt, tgt_q;
  logic [DT_W-1:0] dt_cnt_q, dt_cnt_d, dt_load;
  state_t state_q, state_d;
  logic [2:0] gate_h_q, gate_h_d, gate_l_q, gate_l_d;
  logic hall_chg, moved, old_ok, new_ok, fwd, rev, counted, tgt_chg;
  function automatic logic [2:0] decode(input logic [2:0] h);
    case (h)
      3'b101:  decode = 3'd0;
      3'b100:  decode = 3'd1;
      3'b110:  decode = 3'd2;
      3'b010:  decode = 3'd3;
      3'b011:  decode = 3'd4;
      3'b001:  decode = 3'd5;
      default: decode = 3'd7;
    endcase
  endfunction
  // {H,L} per sector; sector 7 yields all off
  function automatic logic [5:0] pattern(input logic [2:0] s, input logic d);
    case (s)
      3'd0:    pattern = d ? 6'b001_010 : 6'b010_001;
      3'd1:    pattern = d ? 6'b100_010 : 6'b010_100;
      3'd2:    pattern = d ? 6'b100_001 : 6'b001_100;
      3'd3:    pattern = d ? 6'b010_001 : 6'b001_010;
      3'd4:    pattern = d ? 6'b010_100 : 6'b100_010;
      3'd5:    pattern = d ? 6'b001_100 : 6'b100_001;
      default: pattern = 6'b000_000;
    endcase
  endfunction
  always_comb begin
    // the stability count restarts at 1 on the first cycle of a new synced value
    hall_chg = hall_s2_q != hall_last_q;
    filt_cnt_d = hall_chg ? 8'd1 : (filt_cnt_q < FL ? filt_cnt_q + 8'd1 : filt_cnt_q);
    hall_filt_d = (!hall_chg && filt_cnt_q >= FL) ? hall_last_q : hall_filt_q;
    comm_state_d = decode(hall_filt_q);
    moved = comm_state_d != comm_state_q;
    old_ok = comm_state_q != 3'd7;
    new_ok = comm_state_d != 3'd7;
    fwd = comm_state_d == (comm_state_q == 3'd5 ? 3'd0 : comm_state_q + 3'd1);
    rev = comm_state_d == (comm_state_q == 3'd0 ? 3'd5 : comm_state_q - 3'd1);
    counted = moved && old_ok && new_ok && (fwd || rev);
    hall_error_d = moved && (!new_ok || (old_ok && !fwd && !rev));
    step_count_d = counted ? step_count_q + (fwd ? STEP_W'(1) : {STEP_W{1'b1}}) : step_count_q;
    // cleared to 1 so a step N cycles after the previous one reads N
    per_cnt_d = counted ? PERIOD_W'(1) : (per_cnt_q == PER_MAX ? per_cnt_q : per_cnt_q + PERIOD_W'(1));
    step_period_d = counted ? per_cnt_q : (per_cnt_q == PER_MAX ? PER_MAX : step_period_q);
  end
  always_comb begin
    tgt = brake ? 6'b000_111 : (enable ? pattern(comm_state_q, dir) : 6'b000_000);
    tgt_chg = tgt != tgt_q;
    dt_load = deadtime == '0 ? DT_W'(1) : deadtime;
    state_d = state_q;
    dt_cnt_d = dt_cnt_q;
    if (!fault_s2_q) state_d = FAULT;
    else begin
      case (state_q)
        IDLE: if (tgt != '0) begin
          state_d = DEADTIME;
          dt_cnt_d = dt_load;
        end
        DEADTIME: if (tgt_chg) dt_cnt_d = dt_load;
          else if (dt_cnt_q == DT_W'(1)) state_d = tgt != '0 ? DRIVE : IDLE;
          else dt_cnt_d = dt_cnt_q - DT_W'(1);
        DRIVE: if (tgt_chg) begin
          state_d = DEADTIME;
          dt_cnt_d = dt_load;
        end
        FAULT: if (!enable) state_d = IDLE;
      endcase
    end
    // gates follow the next state so the first off cycle coincides with the target change
    gate_h_d = state_d == DRIVE ? tgt[5:3] & {3{pwm_in}} : 3'b000;
    gate_l_d = state_d == DRIVE ? tgt[2:0] : 3'b000;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hall_s1_q     <= '0;
      hall_s2_q     <= '0;
      hall_last_q   <= '0;
      hall_filt_q   <= '0;
      filt_cnt_q    <= '0;
      fault_s1_q    <= 1'b1;
      fault_s2_q    <= 1'b1;
      comm_state_q  <= 3'd7;
      hall_error_q  <= 1'b0;
      step_count_q  <= '0;
      per_cnt_q     <= '0;
      step_period_q <= PER_MAX;
      tgt_q         <= '0;
      dt_cnt_q      <= '0;
      state_q       <= IDLE;
      gate_h_q      <= '0;
      gate_l_q      <= '0;
    end else begin
      hall_s1_q     <= hall;
      hall_s2_q     <= hall_s1_q;
      hall_last_q   <= hall_s2_q;
      hall_filt_q   <= hall_filt_d;
      filt_cnt_q    <= filt_cnt_d;
      fault_s1_q    <= fault_n;
      fault_s2_q    <= fault_s1_q;
      comm_state_q  <= comm_state_d;
      hall_error_q  <= hall_error_d;
      step_count_q  <= step_count_d;
      per_cnt_q     <= per_cnt_d;
      step_period_q <= step_period_d;
      tgt_q         <= tgt;
      dt_cnt_q      <= dt_cnt_d;
      state_q       <= state_d;
      gate_h_q      <= gate_h_d;
      gate_l_q      <= gate_l_d;
    end
  end
  assign gate_h        = gate_h_q;
  assign gate_l        = gate_l_q;
  assign comm_state    = comm_state_q;
  assign hall_error    = hall_error_q;
  assign fault_latched = state_q == FAULT;
  assign step_count    = step_count_q;
  assign step_period   = step_period_q;
endmodule

// File: tb/tb_bldc_commutator.sv
// tb_bldc_commutator: directed checks of filtering, commutation, dead time, step accounting, fault and brake
module tb_bldc_commutator;
  logic clk = 1'b0, reset = 1'b1;
  logic [2:0] hall = 3'b101;
  logic pwm_in = 1'b1, dir = 1'b1, enable = 1'b1, brake = 1'b0, fault_n = 1'b1;
  logic [11:0] deadtime = 12'd10;
  logic [2:0] gate_h, gate_l, comm_state;
  logic hall_error, fault_latched;
  logic signed [31:0] step_count;
  logic [11:0] step_period;
  int checks = 0, errors = 0, cyc = 0, herr_n = 0, next_t = 0, h0 = 0;
  bldc_commutator #(.PERIOD_W(12)) dut (
    .clk(clk), .reset(reset), .hall(hall), .pwm_in(pwm_in), .dir(dir), .enable(enable),
    .brake(brake), .fault_n(fault_n), .deadtime(deadtime), .gate_h(gate_h), .gate_l(gate_l),
    .comm_state(comm_state), .hall_error(hall_error), .fault_latched(fault_latched),
    .step_count(step_count), .step_period(step_period)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (hall_error) herr_n++;
  always @(negedge clk) check("overlap", 32'(gate_h & gate_l), 32'd0);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_off(input string tag);
    int n = 0;
    while ((gate_h | gate_l) != 3'b000 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_off_tmo"}, 32'(n < 100), 32'd1);
  endtask
  task automatic wait_on(input string tag);
    int n = 0;
    while ((gate_h | gate_l) == 3'b000 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_on_tmo"}, 32'(n < 200), 32'd1);
  endtask
  task automatic count_off(input string tag, input int exp_off);
    int n = 0;
    while ((gate_h | gate_l) == 3'b000 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_dead"}, 32'(n), 32'(exp_off));
  endtask
  task automatic gates(input string tag, input logic [2:0] eh, input logic [2:0] el);
    check({tag, "_h"}, 32'(gate_h), 32'(eh));
    check({tag, "_l"}, 32'(gate_l), 32'(el));
  endtask
  task automatic hall_step(input string tag, input logic [2:0] h, input logic [2:0] eh, input logic [2:0] el);
    while (cyc < next_t) @(negedge clk);
    hall = h;
    next_t = cyc + 1000;
    wait_off(tag);
    count_off(tag, 10);
    gates(tag, eh, el);
  endtask
  initial begin
    tick(2);
    gates("rst", 3'b000, 3'b000);
    check("rst_comm", 32'(comm_state), 32'd7);
    check("rst_herr", 32'(hall_error), 32'd0);
    check("rst_flt", 32'(fault_latched), 32'd0);
    check("rst_cnt", step_count, 32'd0);
    check("rst_per", 32'(step_period), 32'hFFF);
    reset = 1'b0;
    tick(20);
    gates("pre", 3'b000, 3'b000);
    wait_on("start");
    gates("start", 3'b001, 3'b010);
    check("start_comm", 32'(comm_state), 32'd0);
    next_t = cyc + 100;
    hall_step("fB", 3'b100, 3'b100, 3'b010);
    check("fB_comm", 32'(comm_state), 32'd1);
    hall_step("fC", 3'b110, 3'b100, 3'b001);
    hall_step("fD", 3'b010, 3'b010, 3'b001);
    hall_step("fE", 3'b011, 3'b010, 3'b100);
    hall_step("fF", 3'b001, 3'b001, 3'b100);
    hall_step("fA", 3'b101, 3'b001, 3'b010);
    check("fwd_cnt", step_count, 32'd6);
    check("fwd_per", 32'(step_period), 32'd1000);
    hall_step("rF", 3'b001, 3'b001, 3'b100);
    hall_step("rE", 3'b011, 3'b010, 3'b100);
    check("rev_cnt", step_count, 32'd4);
    h0 = herr_n;
    hall = 3'b000;
    tick(5);
    hall = 3'b011;
    tick(40);
    check("glitch_comm", 32'(comm_state), 32'd4);
    check("glitch_herr", 32'(herr_n - h0), 32'd0);
    check("glitch_cnt", step_count, 32'd4);
    hall_step("F2", 3'b001, 3'b001, 3'b100);
    hall_step("A2", 3'b101, 3'b001, 3'b010);
    check("A2_cnt", step_count, 32'd6);
    check("A2_per", 32'(step_period), 32'd1000);
    h0 = herr_n;
    hall_step("skip", 3'b110, 3'b100, 3'b001);
    check("skip_comm", 32'(comm_state), 32'd2);
    check("skip_herr", 32'(herr_n - h0), 32'd1);
    check("skip_cnt", step_count, 32'd6);
    while (cyc < next_t) @(negedge clk);
    h0 = herr_n;
    hall = 3'b111;
    tick(60);
    check("inv_comm", 32'(comm_state), 32'd7);
    gates("inv", 3'b000, 3'b000);
    check("inv_herr", 32'(herr_n - h0), 32'd1);
    hall = 3'b101;
    wait_on("rec");
    gates("rec", 3'b001, 3'b010);
    check("rec_cnt", step_count, 32'd6);
    tick(5);
    fault_n = 1'b0;
    tick(1);
    fault_n = 1'b1;
    tick(2);
    check("flt_on", 32'(fault_latched), 32'd1);
    gates("flt", 3'b000, 3'b000);
    tick(20);
    check("flt_hold", 32'(fault_latched), 32'd1);
    gates("flt_hold", 3'b000, 3'b000);
    enable = 1'b0;
    tick(2);
    check("flt_clr", 32'(fault_latched), 32'd0);
    enable = 1'b1;
    tick(1);
    count_off("reen", 10);
    gates("reen", 3'b001, 3'b010);
    tick(5);
    deadtime = 12'd0;
    dir = 1'b0;
    wait_off("dir");
    count_off("dir", 1);
    gates("dir", 3'b010, 3'b001);
    tick(5);
    deadtime = 12'd10;
    brake = 1'b1;
    wait_off("brk");
    count_off("brk", 10);
    gates("brk", 3'b000, 3'b111);
    tick(5);
    brake = 1'b0;
    wait_off("unbrk");
    count_off("unbrk", 10);
    gates("unbrk", 3'b010, 3'b001);
    pwm_in = 1'b0;
    tick(1);
    gates("pwm0", 3'b000, 3'b001);
    pwm_in = 1'b1;
    tick(1);
    gates("pwm1", 3'b010, 3'b001);
    tick(4200);
    check("stall_per", 32'(step_period), 32'hFFF);
    check("stall_cnt", step_count, 32'd6);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
